jtag_scan_master: RTL and testbench

//  JTAG initiator: turns one-shot scan commands on the system clock into TCK/TMS/TDI

---
 rtl/jtag_master_pkg.sv | 12 +
 rtl/jtag_tck_gen.sv | 38 +++
 rtl/jtag_scan_master.sv | 143 ++++++++++++++
 tb/tb_jtag_scan_master.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_master_pkg.sv
// rtl/jtag_master_pkg.sv - state encoding and TMS bit patterns for the JTAG scan master
package jtag_master_pkg;

   typedef enum logic [2:0] {TLR_SEQ, IDLE, HEAD, SHIFT, TAIL} state_e;

   // TMS patterns are LSB first: bit 0 is driven during the first TCK of the phase.
   localparam logic [5:0] TMS_TLR    = 6'b011111;
   localparam logic [2:0] TMS_HDR_DR = 3'b001;
   localparam logic [3:0] TMS_HDR_IR = 4'b0011;
   localparam logic [1:0] TMS_TAIL   = 2'b01;

endpackage

// File: rtl/jtag_tck_gen.sv
// rtl/jtag_tck_gen.sv - TCK divider with strobes flagging the CLK edge that raises or lowers TCK
module jtag_tck_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   output logic tck_o,
   output logic tck_rise_o,
   output logic tck_fall_o
);

   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic             tck_q;
   logic             toggle;

   // Strobes are high in the cycle before TCK changes, so the top can move TMS/TDI on the same edge.
   assign toggle     = en_i && (cnt_q == CNT_MAX);
   assign tck_rise_o = toggle && !tck_q;
   assign tck_fall_o = toggle && tck_q;
   assign tck_o      = tck_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni || !en_i) begin
         cnt_q <= '0;
         tck_q <= 1'b0;
      end else if (toggle) begin
         cnt_q <= '0;
         tck_q <= !tck_q;
      end else begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/jtag_scan_master.sv
// rtl/jtag_scan_master.sv - JTAG initiator: IR/DR scans and TAP resets from a command handshake
module jtag_scan_master
   import jtag_master_pkg::*;
#(
   parameter int DATAWIDTH = 16,
   parameter int CLK_DIV   = 4,
   parameter int LEN_W     = $clog2(DATAWIDTH + 1)
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 CmdValid,
   output logic                 CmdReady,
   input  logic                 CmdTapRst,
   input  logic                 CmdIR,
   input  logic [LEN_W-1:0]     CmdLen,
   input  logic [DATAWIDTH-1:0] CmdData,
   output logic                 RspValid,
   output logic [DATAWIDTH-1:0] RspData,
   output logic                 TCK,
   output logic                 TMS,
   output logic                 TDI,
   input  logic                 TDO
);

   localparam logic [LEN_W-1:0] DW_L = LEN_W'(DATAWIDTH);

   state_e               state_q;
   logic                 tms_q, tdi_q, ready_q, rsp_valid_q, rsp_pend_q;
   logic [DATAWIDTH-1:0] rsp_data_q, tdi_sr_q, cap_q;
   logic [4:0]           pat_q;
   logic [2:0]           cnt_q;
   logic [LEN_W-1:0]     len_q, rem_q, len_d;
   logic                 tck_rise, tck_fall;

   assign len_d = (CmdLen == '0 || CmdLen > DW_L) ? DW_L : CmdLen;

   jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
      .clk_i      (CLK),
      .rst_ni     (RST_N),
      .en_i       (state_q != IDLE),
      .tck_o      (TCK),
      .tck_rise_o (tck_rise),
      .tck_fall_o (tck_fall)
   );

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q     <= TLR_SEQ;
         tms_q       <= TMS_TLR[0];
         tdi_q       <= 1'b0;
         ready_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_pend_q  <= 1'b0;
         rsp_data_q  <= '0;
         tdi_sr_q    <= '0;
         cap_q       <= '0;
         pat_q       <= {1'b0, TMS_TLR[5:1]};
         cnt_q       <= 3'd5;
         len_q       <= DW_L;
         rem_q       <= '0;
      end else begin
         rsp_valid_q <= 1'b0;
         case (state_q)
            IDLE: if (CmdValid && ready_q) begin
               ready_q  <= 1'b0;
               cap_q    <= '0;
               len_q    <= len_d;
               tdi_sr_q <= CmdData;
               if (CmdTapRst) begin
                  state_q    <= TLR_SEQ;
                  rsp_pend_q <= 1'b1;
                  tms_q      <= TMS_TLR[0];
                  pat_q      <= {1'b0, TMS_TLR[5:1]};
                  cnt_q      <= 3'd5;
               end else if (CmdIR) begin
                  state_q <= HEAD;
                  tms_q   <= TMS_HDR_IR[0];
                  pat_q   <= {2'b00, TMS_HDR_IR[3:1]};
                  cnt_q   <= 3'd3;
               end else begin
                  state_q <= HEAD;
                  tms_q   <= TMS_HDR_DR[0];
                  pat_q   <= {3'b000, TMS_HDR_DR[2:1]};
                  cnt_q   <= 3'd2;
               end
            end
            // Fixed-pattern phases walk pat_q one bit per TCK; cnt_q counts bits still to send.
            TLR_SEQ, HEAD, TAIL: if (tck_fall) begin
               if (cnt_q != '0) begin
                  tms_q <= pat_q[0];
                  pat_q <= pat_q >> 1;
                  cnt_q <= cnt_q - 3'd1;
               end else if (state_q == HEAD) begin
                  state_q  <= SHIFT;
                  tms_q    <= (len_q == LEN_W'(1));
                  tdi_q    <= tdi_sr_q[0];
                  tdi_sr_q <= tdi_sr_q >> 1;
                  rem_q    <= len_q - LEN_W'(1);
               end else begin
                  state_q <= IDLE;
                  tms_q   <= 1'b0;
                  tdi_q   <= 1'b0;
                  ready_q <= 1'b1;
                  if (state_q == TAIL) begin
                     rsp_valid_q <= 1'b1;
                     rsp_data_q  <= cap_q >> (DW_L - len_q);
                  end else if (rsp_pend_q) begin
                     rsp_valid_q <= 1'b1;
                     rsp_data_q  <= '0;
                     rsp_pend_q  <= 1'b0;
                  end
               end
            end
            SHIFT: begin
               // TDO enters at the top, so after N bits the first one sits at DATAWIDTH-N.
               if (tck_rise) cap_q <= {TDO, cap_q[DATAWIDTH-1:1]};
               if (tck_fall) begin
                  if (rem_q == '0) begin
                     state_q <= TAIL;
                     tms_q   <= TMS_TAIL[0];
                     tdi_q   <= 1'b0;
                     pat_q   <= {4'b0000, TMS_TAIL[1]};
                     cnt_q   <= 3'd1;
                  end else begin
                     tms_q    <= (rem_q == LEN_W'(1));
                     tdi_q    <= tdi_sr_q[0];
                     tdi_sr_q <= tdi_sr_q >> 1;
                     rem_q    <= rem_q - LEN_W'(1);
                  end
               end
            end
            default: state_q <= TLR_SEQ;
         endcase
      end
   end

   assign CmdReady = ready_q;
   assign RspValid = rsp_valid_q;
   assign RspData  = rsp_data_q;
   assign TMS      = tms_q;
   assign TDI      = tdi_q;

endmodule

// File: tb/tb_jtag_scan_master.sv
// tb/tb_jtag_scan_master.sv - directed bench: TAP model on a CLK_DIV=4 master, loopback on a CLK_DIV=1 master
module tb_jtag_scan_master;

   localparam int DW  = 16;
   localparam int LW  = 5;
   localparam int DIV = 4;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic           RST_N, CmdValid, CmdTapRst, CmdIR, CmdReady, RspValid, TCK, TMS, TDI;
   logic [LW-1:0]  CmdLen;
   logic [DW-1:0]  CmdData, RspData;
   logic           TDO = 1'b0;

   logic           CmdValid1, CmdTapRst1, CmdIR1, CmdReady1, RspValid1, TCK1, TMS1, TDI1;
   logic [LW-1:0]  CmdLen1;
   logic [DW-1:0]  CmdData1, RspData1;
   wire            TDO1;
   assign TDO1 = TDI1;

   jtag_scan_master #(.DATAWIDTH(DW), .CLK_DIV(DIV)) u_dut (
      .CLK(CLK), .RST_N(RST_N), .CmdValid(CmdValid), .CmdReady(CmdReady),
      .CmdTapRst(CmdTapRst), .CmdIR(CmdIR), .CmdLen(CmdLen), .CmdData(CmdData),
      .RspValid(RspValid), .RspData(RspData), .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO)
   );

   jtag_scan_master #(.DATAWIDTH(DW), .CLK_DIV(1)) u_dut1 (
      .CLK(CLK), .RST_N(RST_N), .CmdValid(CmdValid1), .CmdReady(CmdReady1),
      .CmdTapRst(CmdTapRst1), .CmdIR(CmdIR1), .CmdLen(CmdLen1), .CmdData(CmdData1),
      .RspValid(RspValid1), .RspData(RspData1), .TCK(TCK1), .TMS(TMS1), .TDI(TDI1), .TDO(TDO1)
   );

   // Target TAP: 16-bit DR preloaded with 16'h1234, 4-bit IR capturing 4'b0001.
   typedef enum int {T_TLR, T_RTI, T_SELDR, T_CAPDR, T_SHDR, T_EX1DR, T_PAUDR, T_EX2DR, T_UPDR,
                     T_SELIR, T_CAPIR, T_SHIR, T_EX1IR, T_PAUIR, T_EX2IR, T_UPIR} tap_e;
   tap_e        tap    = T_TLR;
   logic [15:0] dr_sh  = 16'h0;
   logic [15:0] dr_reg = 16'h1234;
   logic [3:0]  ir_sh  = 4'h0;
   logic [3:0]  ir_reg = 4'h0;
   bit          tms_hist [512];
   bit          tdi_hist [512];
   int          tck_n  = 0;
   int          rsp_n  = 0;

   always @(posedge TCK) begin
      if (tck_n < 512) begin
         tms_hist[tck_n] = TMS;
         tdi_hist[tck_n] = TDI;
      end
      tck_n++;
      case (tap)
         T_CAPDR: dr_sh = dr_reg;
         T_SHDR:  dr_sh = {TDI, dr_sh[15:1]};
         T_UPDR:  dr_reg = dr_sh;
         T_CAPIR: ir_sh = 4'b0001;
         T_SHIR:  ir_sh = {TDI, ir_sh[3:1]};
         T_UPIR:  ir_reg = ir_sh;
         default: ;
      endcase
      case (tap)
         T_TLR:   tap = TMS ? T_TLR   : T_RTI;
         T_RTI:   tap = TMS ? T_SELDR : T_RTI;
         T_SELDR: tap = TMS ? T_SELIR : T_CAPDR;
         T_CAPDR: tap = TMS ? T_EX1DR : T_SHDR;
         T_SHDR:  tap = TMS ? T_EX1DR : T_SHDR;
         T_EX1DR: tap = TMS ? T_UPDR  : T_PAUDR;
         T_PAUDR: tap = TMS ? T_EX2DR : T_PAUDR;
         T_EX2DR: tap = TMS ? T_UPDR  : T_SHDR;
         T_UPDR:  tap = TMS ? T_SELDR : T_RTI;
         T_SELIR: tap = TMS ? T_TLR   : T_CAPIR;
         T_CAPIR: tap = TMS ? T_EX1IR : T_SHIR;
         T_SHIR:  tap = TMS ? T_EX1IR : T_SHIR;
         T_EX1IR: tap = TMS ? T_UPIR  : T_PAUIR;
         T_PAUIR: tap = TMS ? T_EX2IR : T_PAUIR;
         T_EX2IR: tap = TMS ? T_UPIR  : T_SHIR;
         default: tap = TMS ? T_SELDR : T_RTI;
      endcase
   end

   always @(negedge TCK)
      TDO = (tap == T_SHDR) ? dr_sh[0] : (tap == T_SHIR) ? ir_sh[0] : 1'b0;

   always @(posedge CLK) if (RspValid === 1'b1) rsp_n++;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [63:0] tms_seq(input int s, input int n);
      logic [63:0] v = '0;
      for (int i = 0; i < n && i < 64; i++) v[i] = tms_hist[(s + i) % 512];
      return v;
   endfunction

   function automatic int tdi_ones(input int s, input int n);
      int c = 0;
      for (int i = 0; i < n; i++) c += int'(tdi_hist[(s + i) % 512]);
      return c;
   endfunction

   task automatic run_cmd(input logic rst, input logic ir, input logic [LW-1:0] len,
                          input logic [DW-1:0] data, output int lat, output int start);
      int n = 0;
      @(negedge CLK);
      while (CmdReady !== 1'b1 && n < 2000) begin @(negedge CLK); n++; end
      check("cmd_ready", CmdReady, 1'b1);
      CmdValid = 1'b1; CmdTapRst = rst; CmdIR = ir; CmdLen = len; CmdData = data;
      @(posedge CLK);
      start = tck_n;
      #1 CmdValid = 1'b0; CmdTapRst = 1'b0; CmdIR = 1'b0; CmdLen = '0; CmdData = '0;
      lat = 0;
      do begin @(negedge CLK); lat++; end while (RspValid !== 1'b1 && lat < 3000);
   endtask

   task automatic wait_rsp1(output int lat);
      lat = 0;
      do begin @(negedge CLK); lat++; end while (RspValid1 !== 1'b1 && lat < 500);
   endtask

   int lat, s, r0, n;

   initial begin
      RST_N = 1'b0; CmdValid = 1'b0; CmdTapRst = 1'b0; CmdIR = 1'b0; CmdLen = '0; CmdData = '0;
      CmdValid1 = 1'b0; CmdTapRst1 = 1'b0; CmdIR1 = 1'b0; CmdLen1 = '0; CmdData1 = '0;
      repeat (3) @(posedge CLK);
      #1;
      check("reset_pins", {TCK, TMS, TDI, CmdReady, RspValid}, 5'b01000);
      check("reset_rspdata", RspData, 16'h0);

      // Auto TAP reset after release.
      @(negedge CLK);
      RST_N = 1'b1; s = tck_n; r0 = rsp_n;
      repeat (12 * DIV - 1) @(posedge CLK);
      #1 check("ready_early", CmdReady, 1'b0);
      @(posedge CLK);
      #1 check("ready_after_tlr", CmdReady, 1'b1);
      check("tlr_tck_count", tck_n - s, 6);
      check("tlr_tms", tms_seq(s, 6), 64'h1F);
      check("tlr_no_rsp", rsp_n - r0, 0);
      check("tlr_idle_pins", {TCK, TMS, TDI}, 3'b000);

      // DR scan, 16 bits.
      run_cmd(1'b0, 1'b0, 5'd16, 16'hA5C3, lat, s);
      check("dr16_latency", lat, 21 * 2 * DIV + 1);
      check("dr16_rspdata", RspData, 16'h1234);
      check("dr16_tck_count", tck_n - s, 21);
      check("dr16_tms", tms_seq(s, 21), 64'hC0001);
      check("dr16_target_dr", dr_reg, 16'hA5C3);
      check("dr16_ready", CmdReady, 1'b1);

      // IR scan, 4 bits.
      run_cmd(1'b0, 1'b1, 5'd4, 16'h000E, lat, s);
      check("ir4_latency", lat, 10 * 2 * DIV + 1);
      check("ir4_rspdata", RspData, 16'h0001);
      check("ir4_tms", tms_seq(s, 10), 64'h183);
      check("ir4_target_ir", ir_reg, 4'hE);

      // TAP reset command.
      run_cmd(1'b1, 1'b0, 5'd3, 16'hFFFF, lat, s);
      check("taprst_latency", lat, 6 * 2 * DIV + 1);
      check("taprst_rspdata", RspData, 16'h0);
      check("taprst_tms", tms_seq(s, 6), 64'h1F);
      check("taprst_tdi_ones", tdi_ones(s, 6), 0);

      // Len=0 clamps to 16.
      run_cmd(1'b0, 1'b0, 5'd0, 16'h0F0F, lat, s);
      check("len0_latency", lat, 21 * 2 * DIV + 1);
      check("len0_tck_count", tck_n - s, 21);
      check("len0_rspdata", RspData, 16'hA5C3);
      check("len0_target_dr", dr_reg, 16'h0F0F);

      // Len=5 with all-ones data.
      run_cmd(1'b0, 1'b0, 5'd5, 16'hFFFF, lat, s);
      check("len5_latency", lat, 10 * 2 * DIV + 1);
      check("len5_rspdata", RspData, 16'h000F);
      check("len5_tms", tms_seq(s, 10), 64'h181);
      check("len5_tdi_ones", tdi_ones(s, 10), 5);
      check("len5_target_dr", dr_reg, 16'hF878);

      // Reset pulse in the middle of a shift.
      @(negedge CLK);
      CmdValid = 1'b1; CmdLen = 5'd16; CmdData = 16'hFFFF;
      @(posedge CLK);
      #1 CmdValid = 1'b0;
      r0 = rsp_n;
      repeat (60) @(posedge CLK);
      @(negedge CLK);
      check("abort_pre_tms", TMS, 1'b0);
      RST_N = 1'b0;
      @(negedge CLK);
      check("abort_pins", {TCK, TMS, TDI, CmdReady, RspValid}, 5'b01000);
      check("abort_rspdata", RspData, 16'h0);
      RST_N = 1'b1; s = tck_n;
      repeat (12 * DIV) @(posedge CLK);
      #1 check("abort_ready", CmdReady, 1'b1);
      check("abort_tlr_tms", tms_seq(s, 6), 64'h1F);
      check("abort_tck_count", tck_n - s, 6);
      check("abort_no_rsp", rsp_n - r0, 0);
      check("abort_tap_rti", tap, T_RTI);

      // CLK_DIV=1, CmdValid held high across two commands.
      n = 0;
      @(negedge CLK);
      while (CmdReady1 !== 1'b1 && n < 200) begin @(negedge CLK); n++; end
      check("div1_ready", CmdReady1, 1'b1);
      CmdValid1 = 1'b1; CmdLen1 = 5'd16; CmdData1 = 16'h3C5A;
      @(posedge CLK);
      #1 CmdLen1 = 5'd8; CmdData1 = 16'hABF1;
      wait_rsp1(lat);
      check("div1_lat1", lat, 2 * 21 + 1);
      check("div1_rsp1", RspData1, 16'h3C5A);
      check("div1_ready_in_rsp", CmdReady1, 1'b1);
      @(posedge CLK);
      #1 CmdValid1 = 1'b0;
      wait_rsp1(lat);
      check("div1_lat2", lat, 2 * 13 + 1);
      check("div1_rsp2", RspData1, 16'h00F1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
